// File: rtl/contra_main_cpu.sv
// Contra main-CPU subsystem: compact cen-driven 6809-subset core, work RAM, address decoder,
// ROM banking, cabinet/DIP input mux, sound latch/IRQ and video latches.
module contra_main_cpu #(
    parameter int GAME = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cen12,
    output logic        cpu_cen,
    output logic [17:0] rom_addr,
    output logic        rom_cs,
    input  logic [7:0]  rom_data,
    input  logic        rom_ok,
    input  logic [1:0]  start_button,
    input  logic [1:0]  coin_input,
    input  logic        service,
    input  logic [5:0]  joystick1,
    input  logic [5:0]  joystick2,
    input  logic [7:0]  dipsw_a,
    input  logic [7:0]  dipsw_b,
    input  logic [3:0]  dipsw_c,
    input  logic        dip_pause,
    output logic [15:0] cpu_addr,
    output logic [7:0]  cpu_dout,
    output logic        cpu_rnw,
    output logic        gfx1_cs,
    output logic        gfx2_cs,
    output logic        pal_cs,
    input  logic [7:0]  gfx1_dout,
    input  logic [7:0]  gfx2_dout,
    input  logic [7:0]  pal_dout,
    input  logic        gfx_irqn,
    output logic [7:0]  snd_latch,
    output logic        snd_irq,
    output logic [7:0]  video_bank,
    output logic        prio_latch
);
    // Only the Contra map exists; every variant reads unmapped space as FF.
    localparam logic [7:0] OPEN_BUS = (GAME == 0) ? 8'hFF : 8'hFF;

    typedef enum logic [2:0] {S_IDLE, S_VHI, S_VLO, S_FETCH, S_OP1, S_OP2, S_EXEC} state_t;
    state_t state, state_nx;

    logic [15:0] pc, ea, vec;
    logic [7:0]  op, acc, din;
    logic        iflag, bus_valid, stall, irq_take, wr, ram_cs;
    logic [1:0]  cen_cnt, snd_cnt;
    logic [3:0]  bank;
    logic [7:0]  ram [0:4095];

    function automatic logic has_operand(input logic [7:0] o);
        return (o == 8'h86) || (o == 8'h1C) || (o == 8'h1A) ||
               (o == 8'hB6) || (o == 8'hB7) || (o == 8'h7E);
    endfunction

    function automatic logic is_extended(input logic [7:0] o);
        return (o == 8'hB6) || (o == 8'hB7) || (o == 8'h7E);
    endfunction

    assign bus_valid = (state != S_IDLE);
    assign stall     = rom_cs & ~rom_ok;
    assign cpu_cen   = cen12 & (cen_cnt == 2'd3) & dip_pause & ~stall & bus_valid;
    assign irq_take  = ~gfx_irqn & ~iflag;
    assign wr        = cpu_cen & ~cpu_rnw;
    assign cpu_dout  = acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cen_cnt <= 2'd0;
        else if (cen12) cen_cnt <= cen_cnt + 2'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (state == S_IDLE) begin
            state_nx = S_VHI;
        end else if (cpu_cen) begin
            case (state)
                S_VHI:   state_nx = S_VLO;
                S_VLO:   state_nx = S_FETCH;
                S_FETCH: state_nx = irq_take ? S_VHI : (has_operand(din) ? S_OP1 : S_FETCH);
                S_OP1:   state_nx = is_extended(op) ? S_OP2 : S_FETCH;
                S_OP2:   state_nx = (op == 8'h7E) ? S_FETCH : S_EXEC;
                default: state_nx = S_FETCH;
            endcase
        end
    end

    always_comb begin
        cpu_addr = 16'h0000;
        cpu_rnw  = 1'b1;
        case (state)
            S_VHI:                   cpu_addr = vec;
            S_VLO:                   cpu_addr = vec | 16'h0001;
            S_FETCH, S_OP1, S_OP2:   cpu_addr = pc;
            S_EXEC: begin
                cpu_addr = ea;
                cpu_rnw  = (op != 8'hB7);
            end
            default:                 cpu_addr = 16'h0000;
        endcase
    end

    // Core registers advance only on the E-clock enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc    <= 16'h0000;
            ea    <= 16'h0000;
            vec   <= 16'hFFFE;
            op    <= 8'h00;
            acc   <= 8'h00;
            iflag <= 1'b1;
        end else if (cpu_cen) begin
            case (state)
                S_VHI: pc[15:8] <= din;
                S_VLO: pc[7:0]  <= din;
                S_FETCH: begin
                    if (irq_take) begin
                        vec   <= 16'hFFF8;
                        iflag <= 1'b1;
                    end else begin
                        op <= din;
                        pc <= pc + 16'd1;
                    end
                end
                S_OP1: begin
                    pc       <= pc + 16'd1;
                    ea[15:8] <= din;
                    if (op == 8'h86) acc   <= din;
                    if (op == 8'h1C) iflag <= iflag & din[4];
                    if (op == 8'h1A) iflag <= iflag | din[4];
                end
                S_OP2: begin
                    ea[7:0] <= din;
                    if (op == 8'h7E) pc <= {ea[15:8], din};
                    else             pc <= pc + 16'd1;
                end
                S_EXEC: if (op == 8'hB6) acc <= din;
                default: ;
            endcase
        end
    end

    always_comb begin
        gfx1_cs  = bus_valid & ((cpu_addr[15:3] == 13'h0000) | (cpu_addr[15:13] == 3'b001));
        gfx2_cs  = bus_valid & ((cpu_addr[15:3] == 13'h000C) | (cpu_addr[15:13] == 3'b010));
        pal_cs   = bus_valid & (cpu_addr[15:8] == 8'h0C);
        ram_cs   = bus_valid & (cpu_addr[15:12] == 4'h1);
        rom_cs   = bus_valid & (cpu_addr[15:13] >= 3'd3);
        rom_addr = cpu_addr[15] ? {1'b0, 2'b11, cpu_addr[14:0]} : {1'b0, bank, cpu_addr[12:0]};
    end

    always_comb begin
        din = OPEN_BUS;
        if (rom_cs)       din = rom_data;
        else if (gfx1_cs) din = gfx1_dout;
        else if (gfx2_cs) din = gfx2_dout;
        else if (pal_cs)  din = pal_dout;
        else if (ram_cs)  din = ram[cpu_addr[11:0]];
        else begin
            case (cpu_addr)
                16'h0010: din = {3'b111, start_button[1], start_button[0], service, coin_input[1], coin_input[0]};
                16'h0011: din = {2'b11, joystick1[5], joystick1[4], joystick1[2], joystick1[3], joystick1[0], joystick1[1]};
                16'h0012: din = {2'b11, joystick2[5], joystick2[4], joystick2[2], joystick2[3], joystick2[0], joystick2[1]};
                16'h0014: din = dipsw_a;
                16'h0015: din = dipsw_b;
                16'h0016: din = {4'hF, dipsw_c};
                default:  din = OPEN_BUS;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr && ram_cs) ram[cpu_addr[11:0]] <= cpu_dout;
    end

    // Sound IRQ spans one full E-clock period; a new write restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snd_latch  <= 8'h00;
            snd_irq    <= 1'b0;
            snd_cnt    <= 2'd0;
            video_bank <= 8'h00;
            prio_latch <= 1'b0;
            bank       <= 4'h0;
        end else begin
            if (wr) begin
                case (cpu_addr)
                    16'h0018: prio_latch <= cpu_dout[2];
                    16'h001C: snd_latch  <= cpu_dout;
                    16'h001E: video_bank <= cpu_dout;
                    default: ;
                endcase
                if (cpu_addr[15:12] == 4'h7) bank <= cpu_dout[3:0];
            end
            if (wr && cpu_addr == 16'h001A) begin
                snd_irq <= 1'b1;
                snd_cnt <= 2'd3;
            end else if (cen12 && snd_irq) begin
                if (snd_cnt == 2'd0) snd_irq <= 1'b0;
                else                 snd_cnt <= snd_cnt - 2'd1;
            end
        end
    end
endmodule

// File: tb/tb_contra_main_cpu.sv
// Bench for contra_main_cpu: ROM-resident programs drive the core; results are observed on the bus
// and latches and compared with expectations derived from the board's memory map.
module tb_contra_main_cpu;
    logic        clk, rst_n, cen12, cpu_cen, rom_cs, rom_ok, service, dip_pause;
    logic [17:0] rom_addr;
    logic [7:0]  rom_data, dipsw_a, dipsw_b, cpu_dout, gfx1_dout, gfx2_dout, pal_dout;
    logic [7:0]  snd_latch, video_bank;
    logic [1:0]  start_button, coin_input;
    logic [5:0]  joystick1, joystick2;
    logic [3:0]  dipsw_c;
    logic [15:0] cpu_addr;
    logic        cpu_rnw, gfx1_cs, gfx2_cs, pal_cs, gfx_irqn, snd_irq, prio_latch;

    int n_chk = 0, n_fail = 0;
    logic [7:0]  rom_img [0:262143];
    logic [7:0]  prog [$];
    logic [17:0] last_addr;
    int          dly, lat;
    logic        hold_ok, mon_on;
    logic [3:0]  mbank;

    contra_main_cpu #(.GAME(0)) dut (
        .clk(clk), .rst_n(rst_n), .cen12(cen12), .cpu_cen(cpu_cen),
        .rom_addr(rom_addr), .rom_cs(rom_cs), .rom_data(rom_data), .rom_ok(rom_ok),
        .start_button(start_button), .coin_input(coin_input), .service(service),
        .joystick1(joystick1), .joystick2(joystick2), .dipsw_a(dipsw_a), .dipsw_b(dipsw_b),
        .dipsw_c(dipsw_c), .dip_pause(dip_pause), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
        .cpu_rnw(cpu_rnw), .gfx1_cs(gfx1_cs), .gfx2_cs(gfx2_cs), .pal_cs(pal_cs),
        .gfx1_dout(gfx1_dout), .gfx2_dout(gfx2_dout), .pal_dout(pal_dout), .gfx_irqn(gfx_irqn),
        .snd_latch(snd_latch), .snd_irq(snd_irq), .video_bank(video_bank), .prio_latch(prio_latch)
    );

    initial begin
        clk = 0; cen12 = 0;
        forever #20 clk = ~clk;
    end
    always @(posedge clk) begin
        #2 cen12 = ~cen12;
    end

    // SDRAM slot model: data valid after 'lat' extra cycles of a stable address.
    always @(posedge clk) begin
        if (!rom_cs || rom_addr != last_addr) begin
            last_addr <= rom_addr;
            dly <= 0;
        end else if (dly < lat) dly <= dly + 1;
    end
    assign rom_ok   = rom_cs && (rom_addr == last_addr) && (dly >= lat) && !hold_ok;
    assign rom_data = rom_img[rom_addr];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Decoder reference: memory map as address ranges, bank tracked from observed bus writes.
    always @(negedge clk) begin
        int a;
        if (!rst_n) mbank = 4'h0;
        else if (cpu_cen && mon_on) begin
            a = int'(cpu_addr);
            check("gfx1_cs", gfx1_cs, (a <= 7) || (a >= 'h2000 && a <= 'h3FFF));
            check("gfx2_cs", gfx2_cs, (a >= 'h60 && a <= 'h67) || (a >= 'h4000 && a <= 'h5FFF));
            check("pal_cs", pal_cs, a >= 'hC00 && a <= 'hCFF);
            check("rom_cs", rom_cs, a >= 'h6000);
            if (a >= 'h8000)      check("rom_addr_fix", rom_addr, 'h18000 + (a - 'h8000));
            else if (a >= 'h6000) check("rom_addr_bank", rom_addr, int'(mbank) * 'h2000 + (a - 'h6000));
            check("rom_ok_on_cen", rom_cs && !rom_ok, 0);
            if (!cpu_rnw && a >= 'h7000 && a <= 'h7FFF) mbank = cpu_dout[3:0];
        end
    end

    task automatic op_imm(input logic [7:0] o, input logic [7:0] v);
        prog.push_back(o); prog.push_back(v);
    endtask
    task automatic op_ext(input logic [7:0] o, input logic [15:0] a);
        prog.push_back(o); prog.push_back(a[15:8]); prog.push_back(a[7:0]);
    endtask
    task automatic op_halt();
        logic [15:0] here;
        here = 16'h8000 + 16'(prog.size());
        op_ext(8'h7E, here);
    endtask

    task automatic load_prog();
        for (int i = 0; i < 32768; i++) rom_img[18'h18000 + i] = 8'h12;
        foreach (prog[i]) rom_img[18'h18000 + i] = prog[i];
        rom_img[18'h1FFFE] = 8'h80;
        rom_img[18'h1FFFF] = 8'h00;
        prog.delete();
    endtask

    task automatic do_reset();
        @(negedge clk); rst_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    task automatic wait_bus(input logic [15:0] a, input logic rnw, input string nm);
        int n;
        n = 0;
        do begin
            @(negedge clk); n++;
        end while (!(cpu_cen && cpu_addr == a && cpu_rnw == rnw) && n < 800);
        check({nm, "_reached"}, (cpu_cen && cpu_addr == a && cpu_rnw == rnw), 1);
    endtask

    function automatic logic [7:0] joy_model(input logic [5:0] j);
        return 8'hC0 + 8'(j[5]) * 32 + 8'(j[4]) * 16 + 8'(j[2]) * 8 + 8'(j[3]) * 4 + 8'(j[0]) * 2 + 8'(j[1]);
    endfunction
    function automatic logic [7:0] io_model(input logic [15:0] a);
        case (a)
            16'h0010: return 8'hE0 + 8'(start_button) * 8 + 8'(service) * 4 + 8'(coin_input);
            16'h0011: return joy_model(joystick1);
            16'h0012: return joy_model(joystick2);
            16'h0014: return dipsw_a;
            16'h0015: return dipsw_b;
            16'h0016: return 8'hF0 + 8'(dipsw_c);
            default:  return 8'hFF;
        endcase
    endfunction

    // Read one address through the CPU and expose the value on a probe store to 0800.
    task automatic read_probe(input logic [15:0] a, input logic [7:0] exp, input string nm);
        op_ext(8'hB6, a); op_ext(8'hB7, 16'h0800); op_halt(); load_prog();
        do_reset();
        wait_bus(16'h0800, 1'b0, nm);
        check(nm, cpu_dout, exp);
    endtask

    typedef struct {
        logic [1:0]  start, coin;
        logic        svc;
        logic [5:0]  j1, j2;
        logic [7:0]  da, db;
        logic [3:0]  dc;
        logic [15:0] addr;
        logic [7:0]  exp;
    } vec_t;
    vec_t tbl [$];

    initial begin
        int cnt;
        logic [15:0] ra;
        logic [7:0]  rv;
        logic        done;
        rst_n = 0; hold_ok = 0; mon_on = 1; lat = 1; dip_pause = 1; gfx_irqn = 1;
        start_button = 2'b11; coin_input = 2'b11; service = 1;
        joystick1 = 6'h3F; joystick2 = 6'h3F; dipsw_a = 8'hFF; dipsw_b = 8'hFF; dipsw_c = 4'hF;
        gfx1_dout = 8'h11; gfx2_dout = 8'h22; pal_dout = 8'h33;
        repeat (3) @(negedge clk);

        tbl.push_back('{2'b11, 2'b10, 1'b1, 6'b111110, 6'h3F, 8'hFF, 8'hFF, 4'h3, 16'h0010, 8'hFE});
        tbl.push_back('{2'b11, 2'b10, 1'b1, 6'b111110, 6'h3F, 8'hFF, 8'hFF, 4'h3, 16'h0011, 8'hFD});
        tbl.push_back('{2'b11, 2'b10, 1'b1, 6'b111110, 6'h3F, 8'hFF, 8'hFF, 4'h3, 16'h0016, 8'hF3});
        tbl.push_back('{2'b01, 2'b11, 1'b0, 6'h3F, 6'b011111, 8'hA5, 8'h3C, 4'h0, 16'h0010, 8'hEB});
        tbl.push_back('{2'b01, 2'b11, 1'b0, 6'h3F, 6'b011111, 8'hA5, 8'h3C, 4'h0, 16'h0012, 8'hDF});
        tbl.push_back('{2'b11, 2'b11, 1'b1, 6'h3F, 6'h3F, 8'hA5, 8'h3C, 4'h0, 16'h0014, 8'hA5});
        tbl.push_back('{2'b11, 2'b11, 1'b1, 6'h3F, 6'h3F, 8'hA5, 8'h3C, 4'h0, 16'h0015, 8'h3C});
        tbl.push_back('{2'b11, 2'b11, 1'b1, 6'h3F, 6'h3F, 8'h00, 8'h00, 4'h0, 16'h0013, 8'hFF});
        tbl.push_back('{2'b11, 2'b11, 1'b1, 6'h3F, 6'h3F, 8'h00, 8'h00, 4'h0, 16'h0800, 8'hFF});
        tbl.push_back('{2'b11, 2'b11, 1'b1, 6'h3F, 6'h3F, 8'h00, 8'h00, 4'h0, 16'h0003, 8'h11});
        tbl.push_back('{2'b11, 2'b11, 1'b1, 6'h3F, 6'h3F, 8'h00, 8'h00, 4'h0, 16'h2000, 8'h11});
        tbl.push_back('{2'b11, 2'b11, 1'b1, 6'h3F, 6'h3F, 8'h00, 8'h00, 4'h0, 16'h0065, 8'h22});
        tbl.push_back('{2'b11, 2'b11, 1'b1, 6'h3F, 6'h3F, 8'h00, 8'h00, 4'h0, 16'h4000, 8'h22});
        tbl.push_back('{2'b11, 2'b11, 1'b1, 6'h3F, 6'h3F, 8'h00, 8'h00, 4'h0, 16'h0C10, 8'h33});
        foreach (tbl[i]) begin
            start_button = tbl[i].start; coin_input = tbl[i].coin; service = tbl[i].svc;
            joystick1 = tbl[i].j1; joystick2 = tbl[i].j2;
            dipsw_a = tbl[i].da; dipsw_b = tbl[i].db; dipsw_c = tbl[i].dc;
            read_probe(tbl[i].addr, tbl[i].exp, $sformatf("tbl%0d_rd_%04h", i, tbl[i].addr));
        end

        // Randomized inputs, ROM latency and RAM traffic against the map model.
        for (int r = 0; r < 16; r++) begin
            lat = $urandom_range(0, 3);
            start_button = 2'($urandom); coin_input = 2'($urandom); service = 1'($urandom);
            joystick1 = 6'($urandom); joystick2 = 6'($urandom);
            dipsw_a = 8'($urandom); dipsw_b = 8'($urandom); dipsw_c = 4'($urandom);
            if (r % 4 == 3) begin
                ra = 16'h1000 + 16'($urandom_range(0, 4095));
                rv = 8'($urandom);
                op_imm(8'h86, rv); op_ext(8'hB7, ra); op_imm(8'h86, ~rv);
                read_probe(ra, rv, $sformatf("rnd%0d_ram_%04h", r, ra));
            end else begin
                case ($urandom_range(0, 5))
                    0: ra = 16'h0010; 1: ra = 16'h0011; 2: ra = 16'h0012;
                    3: ra = 16'h0014; 4: ra = 16'h0015; default: ra = 16'h0016;
                endcase
                read_probe(ra, io_model(ra), $sformatf("rnd%0d_io_%04h", r, ra));
            end
        end
        lat = 1;

        // Reset mid-run clears every latch at once; first fetch after release is the reset vector.
        op_imm(8'h86, 8'h77); op_ext(8'hB7, 16'h001E); op_ext(8'hB7, 16'h001C);
        op_ext(8'hB7, 16'h0018); op_ext(8'hB7, 16'h001A); op_halt(); load_prog();
        do_reset();
        wait_bus(16'h001A, 1'b0, "pre_rst_irq");
        @(posedge clk); #7;
        check("pre_rst_bank", video_bank, 8'h77);
        rst_n = 0; #1;
        check("rst_snd_irq", snd_irq, 0);
        check("rst_snd_latch", snd_latch, 0);
        check("rst_video_bank", video_bank, 0);
        check("rst_prio", prio_latch, 0);
        check("rst_rom_cs", rom_cs, 0);
        check("rst_cpu_cen", cpu_cen, 0);
        check("rst_cs", {gfx1_cs, gfx2_cs, pal_cs}, 0);
        @(negedge clk); @(negedge clk); rst_n = 1;
        cnt = 0;
        while (!rom_cs && cnt < 10) begin @(negedge clk); cnt++; end
        check("first_fetch_addr", rom_addr, 18'h1FFFE);

        // ROM banking through 7000.
        op_imm(8'h86, 8'h05); op_ext(8'hB7, 16'h7000); op_ext(8'hB6, 16'h6000); op_ext(8'hB7, 16'h0800);
        op_ext(8'hB6, 16'h8123); op_ext(8'hB7, 16'h0800); op_halt(); load_prog();
        rom_img[18'h0A000] = 8'h9C; rom_img[18'h18123] = 8'h4B;
        do_reset();
        wait_bus(16'h6000, 1'b1, "bank_rd");
        check("bank_rom_addr", rom_addr, 18'h0A000);
        wait_bus(16'h0800, 1'b0, "bank_probe");
        check("bank_data", cpu_dout, 8'h9C);
        wait_bus(16'h8123, 1'b1, "fix_rd");
        check("fix_rom_addr", rom_addr, 18'h18123);
        wait_bus(16'h0800, 1'b0, "fix_probe");
        check("fix_data", cpu_dout, 8'h4B);

        // Sound latch and IRQ length in cen12 pulses.
        op_imm(8'h86, 8'h5A); op_ext(8'hB7, 16'h001C); op_ext(8'hB7, 16'h001A); op_halt(); load_prog();
        do_reset();
        wait_bus(16'h001A, 1'b0, "snd_wr");
        cnt = 0; done = 0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            if (cen12) begin
                if (snd_irq) cnt++;
                else done = 1;
            end
        end
        check("snd_latch", snd_latch, 8'h5A);
        check("snd_irq_pulses", cnt, 4);

        // ROM wait and pause freeze the E-clock.
        op_imm(8'h86, 8'h01); op_halt(); load_prog();
        do_reset();
        repeat (30) @(negedge clk);
        while (!rom_cs) @(negedge clk);
        hold_ok = 1; cnt = 0;
        repeat (20) begin @(negedge clk); if (cpu_cen) cnt++; end
        check("stall_no_cen", cnt, 0);
        hold_ok = 0; dip_pause = 0; cnt = 0;
        repeat (40) begin @(negedge clk); if (cpu_cen) cnt++; end
        check("pause_no_cen", cnt, 0);
        dip_pause = 1; cnt = 0;
        repeat (40) begin @(negedge clk); if (cpu_cen) cnt++; end
        check("resume_cen", cnt > 0, 1);

        // Priority/video latches and a video-region write strobe.
        op_imm(8'h86, 8'h04); op_ext(8'hB7, 16'h0018); op_imm(8'h86, 8'hC3); op_ext(8'hB7, 16'h001E);
        op_ext(8'hB7, 16'h2100); op_halt(); load_prog();
        do_reset();
        wait_bus(16'h2100, 1'b0, "gfx_wr");
        check("gfx_wr_cs", gfx1_cs, 1);
        check("gfx_wr_rnw", cpu_rnw, 0);
        check("gfx_wr_data", cpu_dout, 8'hC3);
        check("prio_latch", prio_latch, 1);
        check("video_bank", video_bank, 8'hC3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
